// File: rtl/tt_sweep_pkg.sv
// -----------------------------------------------------------------------------
// tt_sweep_pkg
// Shared types and widths for the el_truthtable sweep sequencer.
//   state_t  : sequencer states (IDLE, DRIVE, SAMPLE, DONE)
//   *_W      : field widths of the truth-table interface and the accumulators
//   LAST_VEC : index of the final vector in a sweep
// -----------------------------------------------------------------------------
package tt_sweep_pkg;

   localparam int A_W     = 3;
   localparam int B_W     = 4;
   localparam int Y_W     = 3;
   localparam int VEC_W   = 8;
   localparam int NUM_VEC = 256;
   localparam int SUM_W   = 11;
   localparam int CNT_W   = 9;

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/tt_sweep_acc.sv
// -----------------------------------------------------------------------------
// tt_sweep_acc
// Result accumulator for the truth-table sweep.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero both accumulators (start of a new sweep)
//   capture    : add the current y sample
//   y          : sampled el_truthtable output
//   target     : y value that is counted as a hit
//   sum_y      : running sum of captured y
//   hit_cnt    : running count of captured y == target
// -----------------------------------------------------------------------------
module tt_sweep_acc
   import tt_sweep_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             capture,
   input  logic [Y_W-1:0]   y,
   input  logic [Y_W-1:0]   target,
   output logic [SUM_W-1:0] sum_y,
   output logic [CNT_W-1:0] hit_cnt
);

   logic hit;

   assign hit = (y == target);

   // 256 * 7 = 1792 and 256 hits both fit, so neither sum can wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_y   <= '0;
         hit_cnt <= '0;
      end else if (clear) begin
         sum_y   <= '0;
         hit_cnt <= '0;
      end else if (capture) begin
         sum_y   <= sum_y + SUM_W'(y);
         hit_cnt <= hit_cnt + CNT_W'(hit);
      end
   end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tt_sweep_ctrl
// Built-in self-test sequencer: walks all 256 {a,b,x} vectors through
// el_truthtable, accumulates y, and compares against expected totals.
//   Parameters: EXP_SUM, EXP_HITS (expected totals), TARGET_Y (hit value)
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, hold, abort : sweep control (abort > hold > sequencing)
//   ack                : release DONE back to IDLE, results kept
//   tt_a, tt_b, tt_x   : registered vector driven into el_truthtable
//   tt_y               : el_truthtable response
//   busy, done, pass   : status; pass is meaningful only in DONE
//   sum_y, hit_cnt     : accumulated results
//   vec_idx            : current vector index
// -----------------------------------------------------------------------------
module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter logic [SUM_W-1:0] EXP_SUM  = 11'd0,
   parameter logic [CNT_W-1:0] EXP_HITS = 9'd0,
   parameter logic [Y_W-1:0]   TARGET_Y = 3'd0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             hold,
   input  logic             abort,
   input  logic             ack,
   output logic [A_W-1:0]   tt_a,
   output logic [B_W-1:0]   tt_b,
   output logic             tt_x,
   input  logic [Y_W-1:0]   tt_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SUM_W-1:0] sum_y,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [VEC_W-1:0] vec_idx
);

   state_t           state, state_nxt;
   logic [VEC_W-1:0] vec_nxt;
   logic             clear;
   logic             capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         vec_idx <= '0;
         tt_a    <= '0;
         tt_b    <= '0;
         tt_x    <= 1'b0;
      end else begin
         state   <= state_nxt;
         vec_idx <= vec_nxt;
         // Vector fields load together with the index so el_truthtable sees
         // a glitch-free input for the whole DRIVE/SAMPLE pair.
         tt_a    <= vec_nxt[7:5];
         tt_b    <= vec_nxt[4:1];
         tt_x    <= vec_nxt[0];
      end
   end

   always_comb begin
      state_nxt = state;
      vec_nxt   = vec_idx;
      clear     = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = DRIVE;
               vec_nxt   = '0;
               clear     = 1'b1;
            end
         end
         DRIVE: begin
            if (abort)      state_nxt = IDLE;
            else if (!hold) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            // An aborted or held SAMPLE does not capture y.
            if (abort) begin
               state_nxt = IDLE;
            end else if (!hold) begin
               capture = 1'b1;
               if (vec_idx == LAST_VEC) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = DRIVE;
                  vec_nxt   = vec_idx + VEC_W'(1);
               end
            end
         end
         DONE: begin
            // start wins over ack so a restart needs only one cycle.
            if (start) begin
               state_nxt = DRIVE;
               vec_nxt   = '0;
               clear     = 1'b1;
            end else if (ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == DRIVE) || (state == SAMPLE);
   assign done = (state == DONE);
   assign pass = done && (sum_y == EXP_SUM) && (hit_cnt == EXP_HITS);

   tt_sweep_acc u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .capture (capture),
      .y       (tt_y),
      .target  (TARGET_Y),
      .sum_y   (sum_y),
      .hit_cnt (hit_cnt)
   );

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, hold, abort, ack;

   // u0: EXP 896/32, u1: EXP 1792/0, u2: EXP 895/32; all TARGET_Y=0
   logic [2:0]  a0, a1, a2, y0, y1, y2;
   logic [3:0]  b0, b1, b2;
   logic        x0, x1, x2;
   logic        busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
   logic [10:0] sum0, sum1, sum2;
   logic [8:0]  hit0, hit1, hit2;
   logic [7:0]  vec0, vec1, vec2;

   int          y_mode;
   logic [2:0]  lut [256];
   int          prefix [257];
   int          hitpre [257];
   int          exp_sum, exp_hits;
   int          n_checks = 0;
   int          n_fail   = 0;

   // y stub: 0 -> 3'b111, 1 -> tt_a, 2 -> {2'b0,tt_x}, else truth table
   function automatic logic [2:0] stub_y(input int mode, input logic [2:0] a,
                                         input logic x, input logic [2:0] tv);
      case (mode)
         0:       return 3'b111;
         1:       return a;
         2:       return {2'b00, x};
         default: return tv;
      endcase
   endfunction

   assign y0 = stub_y(y_mode, a0, x0, lut[{a0, b0, x0}]);
   assign y1 = stub_y(y_mode, a1, x1, lut[{a1, b1, x1}]);
   assign y2 = stub_y(y_mode, a2, x2, lut[{a2, b2, x2}]);

   tt_sweep_ctrl #(.EXP_SUM(11'd896), .EXP_HITS(9'd32), .TARGET_Y(3'd0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort), .ack(ack),
      .tt_a(a0), .tt_b(b0), .tt_x(x0), .tt_y(y0), .busy(busy0), .done(done0),
      .pass(pass0), .sum_y(sum0), .hit_cnt(hit0), .vec_idx(vec0));

   tt_sweep_ctrl #(.EXP_SUM(11'd1792), .EXP_HITS(9'd0), .TARGET_Y(3'd0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort), .ack(ack),
      .tt_a(a1), .tt_b(b1), .tt_x(x1), .tt_y(y1), .busy(busy1), .done(done1),
      .pass(pass1), .sum_y(sum1), .hit_cnt(hit1), .vec_idx(vec1));

   tt_sweep_ctrl #(.EXP_SUM(11'd895), .EXP_HITS(9'd32), .TARGET_Y(3'd0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort), .ack(ack),
      .tt_a(a2), .tt_b(b2), .tt_x(x2), .tt_y(y2), .busy(busy2), .done(done2),
      .pass(pass2), .sum_y(sum2), .hit_cnt(hit2), .vec_idx(vec2));

   // Reference: totals over the 256 vectors, computed from the vector index.
   task automatic build_model();
      logic [7:0] vv;
      logic [2:0] yv;
      prefix[0] = 0;
      hitpre[0] = 0;
      for (int v = 0; v < 256; v++) begin
         vv = 8'(v);
         yv = stub_y(y_mode, vv[7:5], vv[0], lut[vv]);
         prefix[v+1] = prefix[v] + int'(yv);
         hitpre[v+1] = hitpre[v] + ((yv == 3'd0) ? 1 : 0);
      end
      exp_sum  = prefix[256];
      exp_hits = hitpre[256];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_to_done(output int cycles);
      cycles = 0;
      while (!done0 && cycles <= 2000) begin
         step();
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_checks++;
      if ({a0, b0, x0} !== 8'd0) begin
         n_fail++; $display("FAIL reset_tt got=%h want=00", {a0, b0, x0});
      end
      n_checks++;
      if (vec0 !== 8'd0) begin n_fail++; $display("FAIL reset_vec got=%0d want=0", vec0); end
      n_checks++;
      if (sum0 !== 11'd0 || hit0 !== 9'd0) begin
         n_fail++; $display("FAIL reset_acc got=%0d/%0d want=0/0", sum0, hit0);
      end
      n_checks++;
      if ({busy0, done0, pass0} !== 3'b000) begin
         n_fail++; $display("FAIL reset_status got=%b want=000", {busy0, done0, pass0});
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_all_ones();
      int c;
      y_mode = 0;
      build_model();
      pulse_start();
      n_checks++;
      if (busy0 !== 1'b1) begin n_fail++; $display("FAIL ones_busy got=%b want=1", busy0); end
      run_to_done(c);
      n_checks++;
      if (c !== 512) begin n_fail++; $display("FAIL ones_latency got=%0d want=512", c); end
      n_checks++;
      if (sum0 !== 11'(exp_sum)) begin n_fail++; $display("FAIL ones_sum got=%0d want=%0d", sum0, exp_sum); end
      n_checks++;
      if (hit0 !== 9'(exp_hits)) begin n_fail++; $display("FAIL ones_hits got=%0d want=%0d", hit0, exp_hits); end
      n_checks++;
      if ({pass0, pass1, pass2} !== {exp_sum == 896 && exp_hits == 32,
                                     exp_sum == 1792 && exp_hits == 0,
                                     exp_sum == 895 && exp_hits == 32}) begin
         n_fail++; $display("FAIL ones_pass got=%b want=010", {pass0, pass1, pass2});
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_checks++;
      if ({done0, pass1, sum0} !== {1'b0, 1'b0, 11'(exp_sum)}) begin
         n_fail++; $display("FAIL ones_ack got=%b/%b/%0d want=0/0/%0d", done0, pass1, sum0, exp_sum);
      end
   endtask

   task automatic test_y_eq_a();
      int c;
      y_mode = 1;
      build_model();
      pulse_start();
      repeat (100) step();
      n_checks++;
      if (pass0 !== 1'b0) begin n_fail++; $display("FAIL ya_pass_busy got=%b want=0", pass0); end
      run_to_done(c);
      n_checks++;
      if (c !== 412) begin n_fail++; $display("FAIL ya_latency got=%0d want=412", c); end
      n_checks++;
      if (sum0 !== 11'(exp_sum) || hit0 !== 9'(exp_hits)) begin
         n_fail++; $display("FAIL ya_result got=%0d/%0d want=%0d/%0d", sum0, hit0, exp_sum, exp_hits);
      end
      n_checks++;
      if ({pass0, pass1, pass2} !== 3'b100) begin
         n_fail++; $display("FAIL ya_pass got=%b want=100", {pass0, pass1, pass2});
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_truthtable();
      bit seen_eb, seen_82;
      seen_eb = 0;
      seen_82 = 0;
      y_mode = 3;
      for (int i = 0; i < 256; i++) lut[i] = 3'($urandom);
      build_model();
      pulse_start();
      for (int k = 0; k < 512; k++) begin
         n_checks++;
         if (vec0 !== 8'(k / 2) || sum0 !== 11'(prefix[k/2]) || hit0 !== 9'(hitpre[k/2])) begin
            n_fail++;
            $display("FAIL tt_progress k=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                     k, vec0, sum0, hit0, k / 2, prefix[k/2], hitpre[k/2]);
         end
         if (k % 2 == 0) begin
            n_checks++;
            if ({a0, b0, x0} !== 8'(k / 2)) begin
               n_fail++; $display("FAIL tt_map k=%0d got=%h want=%h", k, {a0, b0, x0}, 8'(k / 2));
            end
            if (vec0 == 8'hEB) begin
               seen_eb = 1;
               n_checks++;
               if ({a0, b0, x0} !== {3'd7, 4'd5, 1'b1}) begin
                  n_fail++; $display("FAIL tt_vec_eb got=%0d/%0d/%0d want=7/5/1", a0, b0, x0);
               end
            end
            if (vec0 == 8'h82) begin
               seen_82 = 1;
               n_checks++;
               if ({a0, b0, x0} !== {3'd4, 4'd1, 1'b0}) begin
                  n_fail++; $display("FAIL tt_vec_82 got=%0d/%0d/%0d want=4/1/0", a0, b0, x0);
               end
            end
         end
         step();
      end
      n_checks++;
      if ({seen_eb, seen_82} !== 2'b11) begin
         n_fail++; $display("FAIL tt_vec_seen got=%b want=11", {seen_eb, seen_82});
      end
      n_checks++;
      if (done0 !== 1'b1 || sum0 !== 11'(exp_sum) || hit0 !== 9'(exp_hits)) begin
         n_fail++; $display("FAIL tt_final got=%b/%0d/%0d want=1/%0d/%0d", done0, sum0, hit0, exp_sum, exp_hits);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_hold();
      int c, hs;
      y_mode = 2;
      build_model();
      hs = 200 + int'($urandom_range(0, 1));
      pulse_start();
      repeat (hs) step();
      hold = 1'b1;
      repeat (10) step();
      hold = 1'b0;
      n_checks++;
      if (vec0 !== 8'd100 || sum0 !== 11'(prefix[100])) begin
         n_fail++; $display("FAIL hold_frozen got=%0d/%0d want=100/%0d", vec0, sum0, prefix[100]);
      end
      run_to_done(c);
      n_checks++;
      if (hs + 10 + c !== 522) begin n_fail++; $display("FAIL hold_latency got=%0d want=522", hs + 10 + c); end
      n_checks++;
      if (sum0 !== 11'(exp_sum)) begin n_fail++; $display("FAIL hold_sum got=%0d want=%0d", sum0, exp_sum); end
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_abort();
      int c, as;
      y_mode = 3;
      for (int i = 0; i < 256; i++) lut[i] = 3'($urandom);
      build_model();
      as = 80 + int'($urandom_range(0, 1));
      pulse_start();
      repeat (as) step();
      n_checks++;
      if (vec0 !== 8'd40) begin n_fail++; $display("FAIL abort_vec got=%0d want=40", vec0); end
      abort = 1'b1;
      hold  = 1'b1;
      step();
      abort = 1'b0;
      hold  = 1'b0;
      n_checks++;
      if ({busy0, done0} !== 2'b00 || sum0 !== 11'(prefix[40]) || hit0 !== 9'(hitpre[40])) begin
         n_fail++; $display("FAIL abort_state got=%b/%0d/%0d want=00/%0d/%0d",
                            {busy0, done0}, sum0, hit0, prefix[40], hitpre[40]);
      end
      abort = 1'b1;
      step();
      step();
      abort = 1'b0;
      n_checks++;
      if ({busy0, done0} !== 2'b00 || sum0 !== 11'(prefix[40])) begin
         n_fail++; $display("FAIL abort_idle got=%b/%0d want=00/%0d", {busy0, done0}, sum0, prefix[40]);
      end
      pulse_start();
      n_checks++;
      if (busy0 !== 1'b1 || vec0 !== 8'd0 || sum0 !== 11'd0 || hit0 !== 9'd0) begin
         n_fail++; $display("FAIL abort_restart got=%b/%0d/%0d/%0d want=1/0/0/0", busy0, vec0, sum0, hit0);
      end
      run_to_done(c);
      n_checks++;
      if (c !== 512 || sum0 !== 11'(exp_sum) || hit0 !== 9'(exp_hits)) begin
         n_fail++; $display("FAIL abort_full got=%0d/%0d/%0d want=512/%0d/%0d", c, sum0, hit0, exp_sum, exp_hits);
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1;
      ack   = 1'b1;
      step();
      start = 1'b0;
      ack   = 1'b0;
      n_checks++;
      if ({busy0, done0} !== 2'b10 || vec0 !== 8'd0 || sum0 !== 11'd0) begin
         n_fail++; $display("FAIL b2b_restart got=%b/%0d/%0d want=10/0/0", {busy0, done0}, vec0, sum0);
      end
      repeat (6) step();
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++;
      if (busy0 !== 1'b1 || vec0 !== 8'd3) begin
         n_fail++; $display("FAIL b2b_start_busy got=%b/%0d want=1/3", busy0, vec0);
      end
      repeat (20) step();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy0, done0, pass0, vec0, a0, b0, x0, sum0, hit0} !== '0) begin
         n_fail++; $display("FAIL async_reset got=%b/%0d/%0d/%0d want=000/0/0/0",
                            {busy0, done0, pass0}, vec0, sum0, hit0);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0; ack = 1'b0;
      y_mode = 0;
      for (int i = 0; i < 256; i++) lut[i] = 3'd0;
      test_reset();
      test_all_ones();
      test_y_eq_a();
      test_truthtable();
      test_hold();
      test_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
